nv_ram_fifo_ctrl_256x128: RTL and testbench

Flow-control front end for the 256x128 two-port register-file RAM (`nv_ram_rws_256x128`-class macro: registered read address, combinational read of the latched row). It turns the RAM into a 256-entry valid/ready FIFO:
- drives the RAM write port from an upstream producer;
- prefetches the RAM read port so the head entry is presented on `rd_pd` with one-cycle write-to-read latency.

No data storage of its own besides pointers and flags; the payload lives entirely in the RAM.

---
 rtl/nv_ram_fifo_ctrl_256x128.sv | 101 ++++++++++
 tb/tb_nv_ram_fifo_ctrl_256x128.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/nv_ram_fifo_ctrl_256x128.sv
// Valid/ready FIFO controller for a 256x128 register-file RAM. Holds only
// pointers and flags; the payload lives in the RAM, the head is prefetched.
module nv_ram_fifo_ctrl_256x128 (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_pvld,
    output logic         wr_prdy,
    input  logic [127:0] wr_pd,
    output logic         rd_pvld,
    input  logic         rd_prdy,
    output logic [127:0] rd_pd,
    output logic [8:0]   fifo_count,
    output logic [7:0]   ram_wa,
    output logic         ram_we,
    output logic [127:0] ram_di,
    output logic [7:0]   ram_ra,
    output logic         ram_re,
    input  logic [127:0] ram_dout
);

    localparam logic [8:0] DEPTH = 9'd256;

    logic [7:0] wr_ptr_r;
    logic [7:0] rd_ptr_r;
    logic [8:0] count_r;
    logic       out_vld_r;
    logic       wr_prdy_r;

    logic       push_s;
    logic       pop_s;
    logic       fetch_s;
    logic [8:0] avail_s;
    logic [8:0] count_nxt_s;
    logic       out_vld_nxt_s;
    logic       wr_prdy_nxt_s;

    // Handshakes and the prefetch decision; avail excludes the entry already presented.
    always_comb begin
        push_s  = wr_pvld & wr_prdy_r;
        pop_s   = out_vld_r & rd_prdy;
        avail_s = count_r - {8'd0, out_vld_r};
        fetch_s = (~out_vld_r | pop_s) & ((avail_s != 9'd0) | push_s);
    end

    // Next occupancy; ready is derived from it so wr_prdy has no input-to-output path.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 9'd1;
            2'b01:   count_nxt_s = count_r - 9'd1;
            default: count_nxt_s = count_r;
        endcase
        wr_prdy_nxt_s = (count_nxt_s != DEPTH);
    end

    // Presented-head valid: a fetch refills it, a pop without refill empties it.
    always_comb begin
        if (fetch_s) begin
            out_vld_nxt_s = 1'b1;
        end else if (pop_s) begin
            out_vld_nxt_s = 1'b0;
        end else begin
            out_vld_nxt_s = out_vld_r;
        end
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r  <= 8'd0;
            rd_ptr_r  <= 8'd0;
            count_r   <= 9'd0;
            out_vld_r <= 1'b0;
            wr_prdy_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 8'd1;
            end
            if (fetch_s) begin
                rd_ptr_r <= rd_ptr_r + 8'd1;
            end
            count_r   <= count_nxt_s;
            out_vld_r <= out_vld_nxt_s;
            wr_prdy_r <= wr_prdy_nxt_s;
        end
    end

    // RAM ports; a same-cycle fetch of the row being written needs no bypass.
    always_comb begin
        ram_we     = push_s;
        ram_wa     = wr_ptr_r;
        ram_di     = wr_pd;
        ram_re     = fetch_s;
        ram_ra     = rd_ptr_r;
        rd_pd      = ram_dout;
        rd_pvld    = out_vld_r;
        wr_prdy    = wr_prdy_r;
        fifo_count = count_r;
    end

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_256x128.sv
// Bench for nv_ram_fifo_ctrl_256x128 with a behavioural RAM; stimulus records
// accepted entries, a negedge monitor checks the DUT against an occupancy model.
module tb_nv_ram_fifo_ctrl_256x128;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_pvld;
    logic         wr_prdy;
    logic [127:0] wr_pd;
    logic         rd_pvld;
    logic         rd_prdy;
    logic [127:0] rd_pd;
    logic [8:0]   fifo_count;
    logic [7:0]   ram_wa;
    logic         ram_we;
    logic [127:0] ram_di;
    logic [7:0]   ram_ra;
    logic         ram_re;
    logic [127:0] ram_dout;

    int vectors = 0;
    int miscompares = 0;

    // Entries accepted by the producer, in order; written only by stimulus.
    logic [127:0] exp_mem [0:16383];
    int issued = 0;

    logic [127:0] mem [0:255];
    logic [7:0]   ra_lat;

    always #5 clk = ~clk;

    nv_ram_fifo_ctrl_256x128 dut (
        .clk(clk), .rst(rst),
        .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
        .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
        .fifo_count(fifo_count),
        .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
        .ram_ra(ram_ra), .ram_re(ram_re), .ram_dout(ram_dout)
    );

    // Register-file RAM: registered read address, combinational read of the latched row.
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_lat <= ram_ra;
    end
    assign ram_dout = mem[ra_lat];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One cycle of stimulus, driven just after the active edge; records an accepted push.
    task automatic cycle(input logic v, input logic [127:0] d, input logic r, output logic acc);
        @(posedge clk);
        #1;
        wr_pvld = v;
        wr_pd   = d;
        rd_prdy = r;
        acc     = v && wr_prdy;
        if (acc) begin
            exp_mem[issued] = d;
            issued++;
        end
    endtask

    task automatic drain();
        logic acc;
        int n;
        n = 0;
        while (fifo_count != 9'd0 && n < 600) begin
            cycle(1'b0, 128'd0, 1'b1, acc);
            n++;
        end
        cycle(1'b0, 128'd0, 1'b0, acc);
        chk("drain_empty", {119'd0, fifo_count}, 128'd0);
    endtask

    // Monitor: occupancy model plus in-order head tracking, checked on every falling edge.
    initial begin
        int n_held, n_next, head_idx, wa_idx, ra_idx;
        logic first, e_prdy, e_push, e_pop, e_re;
        n_held = 0; head_idx = 0; wa_idx = 0; ra_idx = 0; first = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                n_held = 0; head_idx = issued; wa_idx = 0; ra_idx = 0; first = 1'b1;
            end else begin
                e_prdy = first ? 1'b0 : (n_held != 256);
                e_push = wr_pvld && e_prdy;
                e_pop  = (n_held != 0) && rd_prdy;
                n_next = n_held + int'(e_push) - int'(e_pop);
                e_re   = ((n_held == 0) || e_pop) && (n_next != 0);
                chk("fifo_count", {119'd0, fifo_count}, 128'(n_held));
                chk("wr_prdy", {127'd0, wr_prdy}, {127'd0, e_prdy});
                chk("rd_pvld", {127'd0, rd_pvld}, {127'd0, (n_held != 0)});
                chk("ram_we", {127'd0, ram_we}, {127'd0, e_push});
                chk("ram_re", {127'd0, ram_re}, {127'd0, e_re});
                if (e_push) begin
                    chk("ram_wa", {120'd0, ram_wa}, 128'(wa_idx));
                    chk("ram_di", ram_di, wr_pd);
                end
                if (e_re) chk("ram_ra", {120'd0, ram_ra}, 128'(ra_idx));
                if (n_held != 0) chk("rd_pd", rd_pd, exp_mem[head_idx]);
                if (e_pop) head_idx++;
                if (e_push) wa_idx = (wa_idx + 1) % 256;
                if (e_re) ra_idx = (ra_idx + 1) % 256;
                n_held = n_next;
                first = 1'b0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int accepted, budget;
        logic [127:0] d;
        rst = 1'b1; wr_pvld = 1'b0; wr_pd = 128'd0; rd_prdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_fifo_count", {119'd0, fifo_count}, 128'd0);
        chk("reset_wr_prdy", {127'd0, wr_prdy}, 128'd0);
        chk("reset_rd_pvld", {127'd0, rd_pvld}, 128'd0);

        // Single push with consumer ready: one-cycle write-to-read latency.
        cycle(1'b0, 128'd0, 1'b1, acc);
        chk("ready_after_reset", {127'd0, wr_prdy}, 128'd1);
        cycle(1'b1, 128'd1, 1'b1, acc);
        cycle(1'b0, 128'd0, 1'b1, acc);
        @(negedge clk);
        chk("lat_rd_pvld", {127'd0, rd_pvld}, 128'd1);
        chk("lat_rd_pd", rd_pd, 128'd1);
        chk("lat_count", {119'd0, fifo_count}, 128'd1);
        cycle(1'b0, 128'd0, 1'b0, acc);
        @(negedge clk);
        chk("lat_count_after_pop", {119'd0, fifo_count}, 128'd0);

        // Fill to full with consumer stalled.
        accepted = 0; budget = 0;
        while (accepted < 256 && budget < 400) begin
            d = {32'hF111_0000, 64'd0, 32'(accepted)};
            cycle(1'b1, d, 1'b0, acc);
            if (acc) accepted++;
            budget++;
        end
        chk("fill_accepted", 128'(accepted), 128'd256);
        repeat (4) cycle(1'b0, 128'd0, 1'b0, acc);
        @(negedge clk);
        chk("full_wr_prdy", {127'd0, wr_prdy}, 128'd0);
        chk("full_count", {119'd0, fifo_count}, 128'd256);
        chk("full_head", rd_pd, {32'hF111_0000, 96'd0});
        cycle(1'b0, 128'd0, 1'b1, acc);
        cycle(1'b0, 128'd0, 1'b0, acc);
        @(negedge clk);
        chk("unfull_wr_prdy", {127'd0, wr_prdy}, 128'd1);
        chk("unfull_head", rd_pd, {32'hF111_0000, 96'd1});
        chk("unfull_count", {119'd0, fifo_count}, 128'd255);
        drain();

        // Streaming 600 words: pointers wrap twice, occupancy stays at one.
        for (int i = 0; i < 600; i++) begin
            d = {32'h5EED_0000, 64'd0, 32'(i)};
            cycle(1'b1, d, 1'b1, acc);
            if (!acc) chk("stream_accept", 128'd0, 128'd1);
            if (i > 0) begin
                @(negedge clk);
                chk("stream_count", {119'd0, fifo_count}, 128'd1);
            end
        end
        drain();

        // Random traffic at 50% on both sides.
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), rand128(), 1'($urandom_range(0, 1)), acc);
        end
        drain();

        // Fill to 100, then reset mid-cycle.
        accepted = 0; budget = 0;
        while (accepted < 100 && budget < 200) begin
            cycle(1'b1, rand128(), 1'b0, acc);
            if (acc) accepted++;
            budget++;
        end
        cycle(1'b0, 128'd0, 1'b0, acc);
        @(negedge clk);
        chk("pre_reset_count", {119'd0, fifo_count}, 128'd100);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_rd_pvld", {127'd0, rd_pvld}, 128'd0);
        chk("midrst_count", {119'd0, fifo_count}, 128'd0);
        chk("midrst_wr_prdy", {127'd0, wr_prdy}, 128'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(1'b0, 128'd0, 1'b0, acc);
        chk("post_reset_ready", {127'd0, wr_prdy}, 128'd1);
        d = {32'hCAFE_F00D, 32'h0123_4567, 32'h89AB_CDEF, 32'h0BAD_BEEF};
        cycle(1'b1, d, 1'b0, acc);
        cycle(1'b0, 128'd0, 1'b0, acc);
        @(negedge clk);
        chk("post_reset_rd_pvld", {127'd0, rd_pvld}, 128'd1);
        chk("post_reset_rd_pd", rd_pd, d);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
